// File: rtl/dm_arbiter.sv
// Two-port (CPU/DMA) round-robin arbiter in front of a byte-addressed data memory.
// Each access takes three cycles: IDLE samples and captures, ACC drives the memory,
// RSP presents done/err/rdata to the winning port.
module dm_arbiter (
    input  logic        clk,
    input  logic        rstn,
    // Port 0 (CPU)
    input  logic        p0_req,
    input  logic [2:0]  p0_op,
    input  logic [8:0]  p0_addr,
    input  logic [31:0] p0_wdata,
    output logic        p0_gnt,
    output logic        p0_done,
    output logic        p0_err,
    output logic [31:0] p0_rdata,
    // Port 1 (DMA)
    input  logic        p1_req,
    input  logic [2:0]  p1_op,
    input  logic [8:0]  p1_addr,
    input  logic [31:0] p1_wdata,
    output logic        p1_gnt,
    output logic        p1_done,
    output logic        p1_err,
    output logic [31:0] p1_rdata,
    // Memory side
    output logic        dm_we,
    output logic [2:0]  dm_op,
    output logic [8:0]  dm_addr,
    output logic [31:0] dm_din,
    input  logic [31:0] dm_dout
);

    localparam logic [2:0] OpLw  = 3'b000;
    localparam logic [2:0] OpLh  = 3'b001;
    localparam logic [2:0] OpLhu = 3'b010;
    localparam logic [2:0] OpSw  = 3'b101;
    localparam logic [2:0] OpSh  = 3'b110;
    localparam logic [2:0] OpSb  = 3'b111;

    typedef enum logic [1:0] {StIdle, StAcc, StRsp} state_e;

    state_e      state_q, state_d;
    logic        win_q, win_d;       // port owning the current access
    logic        last_q, last_d;     // port granted most recently
    logic        mis_q, mis_d;       // captured access is misaligned
    logic        store_q, store_d;   // captured access is a store
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  done_q, done_d;
    logic [1:0]  err_q, err_d;
    logic [31:0] rdata0_q, rdata0_d;
    logic [31:0] rdata1_q, rdata1_d;
    logic        dm_we_q, dm_we_d;
    logic [2:0]  dm_op_q, dm_op_d;
    logic [8:0]  dm_addr_q, dm_addr_d;
    logic [31:0] dm_din_q, dm_din_d;

    logic        sel;
    logic [2:0]  sel_op;
    logic [8:0]  sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_mis;
    logic        sel_store;
    logic [31:0] load_result;

    function automatic logic is_store(input logic [2:0] op);
        return (op == OpSw) || (op == OpSh) || (op == OpSb);
    endfunction

    function automatic logic is_misaligned(input logic [2:0] op, input logic [8:0] addr);
        logic mis;
        mis = 1'b0;
        case (op)
            OpLw, OpSw:        mis = (addr[1:0] != 2'b00);
            OpLh, OpLhu, OpSh: mis = addr[0];
            default:           mis = 1'b0;
        endcase
        return mis;
    endfunction

    // Winner selection: a lone requester wins; on a tie the port not granted last wins
    always_comb begin
        sel       = p1_req && (!p0_req || !last_q);
        sel_op    = sel ? p1_op    : p0_op;
        sel_addr  = sel ? p1_addr  : p0_addr;
        sel_wdata = sel ? p1_wdata : p0_wdata;
        sel_mis   = is_misaligned(sel_op, sel_addr);
        sel_store = is_store(sel_op);
    end

    // Next-state, capture and output-register logic for the IDLE/ACC/RSP sequence
    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        last_d      = last_q;
        mis_d       = mis_q;
        store_d     = store_q;
        rdata0_d    = rdata0_q;
        rdata1_d    = rdata1_q;
        gnt_d       = 2'b00;
        done_d      = 2'b00;
        err_d       = 2'b00;
        dm_we_d     = 1'b0;
        dm_op_d     = OpLw;
        dm_addr_d   = 9'd0;
        dm_din_d    = 32'd0;
        load_result = (mis_q || store_q) ? 32'd0 : dm_dout;

        unique case (state_q)
            StIdle: begin
                if (p0_req || p1_req) begin
                    state_d        = StAcc;
                    win_d          = sel;
                    last_d         = sel;
                    mis_d          = sel_mis;
                    store_d        = sel_store;
                    gnt_d[sel]     = 1'b1;
                    // A misaligned access is turned into a harmless non-writing LW
                    dm_op_d        = sel_mis ? OpLw : sel_op;
                    dm_we_d        = sel_store && !sel_mis;
                    dm_addr_d      = sel_addr;
                    dm_din_d       = sel_wdata;
                end
            end
            StAcc: begin
                state_d        = StRsp;
                done_d[win_q]  = 1'b1;
                err_d[win_q]   = mis_q;
                if (win_q) begin
                    rdata1_d = load_result;
                end else begin
                    rdata0_d = load_result;
                end
            end
            StRsp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset clears everything, so an in-flight store is dropped
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            win_q     <= 1'b0;
            last_q    <= 1'b1;
            mis_q     <= 1'b0;
            store_q   <= 1'b0;
            gnt_q     <= 2'b00;
            done_q    <= 2'b00;
            err_q     <= 2'b00;
            rdata0_q  <= 32'd0;
            rdata1_q  <= 32'd0;
            dm_we_q   <= 1'b0;
            dm_op_q   <= OpLw;
            dm_addr_q <= 9'd0;
            dm_din_q  <= 32'd0;
        end else begin
            state_q   <= state_d;
            win_q     <= win_d;
            last_q    <= last_d;
            mis_q     <= mis_d;
            store_q   <= store_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            dm_we_q   <= dm_we_d;
            dm_op_q   <= dm_op_d;
            dm_addr_q <= dm_addr_d;
            dm_din_q  <= dm_din_d;
        end
    end

    assign p0_gnt   = gnt_q[0];
    assign p1_gnt   = gnt_q[1];
    assign p0_done  = done_q[0];
    assign p1_done  = done_q[1];
    assign p0_err   = err_q[0];
    assign p1_err   = err_q[1];
    assign p0_rdata = rdata0_q;
    assign p1_rdata = rdata1_q;
    assign dm_we    = dm_we_q;
    assign dm_op    = dm_op_q;
    assign dm_addr  = dm_addr_q;
    assign dm_din   = dm_din_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter: directed accesses push expected responses,
// a monitor pops and compares on every done pulse. Includes a byte memory model.
module tb_dm_arbiter;

    localparam logic [2:0] LW = 3'b000, LH = 3'b001, LHU = 3'b010, LB = 3'b011;
    localparam logic [2:0] LBU = 3'b100, SW = 3'b101, SH = 3'b110, SB = 3'b111;

    logic        clk;
    logic        rstn;
    logic [1:0]  req;
    logic [2:0]  op [2];
    logic [8:0]  addr [2];
    logic [31:0] wdata [2];
    wire  [1:0]  gnt;
    wire  [1:0]  done;
    wire  [1:0]  err;
    wire  [31:0] rd0;
    wire  [31:0] rd1;
    wire         dm_we;
    wire  [2:0]  dm_op;
    wire  [8:0]  dm_addr;
    wire  [31:0] dm_din;
    logic [31:0] dm_dout;

    int n_vec = 0;
    int n_bad = 0;
    int we_cnt = 0;
    logic [32:0] exp0_q [$];
    logic [32:0] exp1_q [$];

    dm_arbiter dut (
        .clk      (clk),
        .rstn     (rstn),
        .p0_req   (req[0]),
        .p0_op    (op[0]),
        .p0_addr  (addr[0]),
        .p0_wdata (wdata[0]),
        .p0_gnt   (gnt[0]),
        .p0_done  (done[0]),
        .p0_err   (err[0]),
        .p0_rdata (rd0),
        .p1_req   (req[1]),
        .p1_op    (op[1]),
        .p1_addr  (addr[1]),
        .p1_wdata (wdata[1]),
        .p1_gnt   (gnt[1]),
        .p1_done  (done[1]),
        .p1_err   (err[1]),
        .p1_rdata (rd1),
        .dm_we    (dm_we),
        .dm_op    (dm_op),
        .dm_addr  (dm_addr),
        .dm_din   (dm_din),
        .dm_dout  (dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Little-endian byte memory; loads are extracted and extended on the memory side
    logic [7:0]  mem [512];
    logic [8:0]  a1, a2, a3;
    logic [31:0] rd_w;
    always_comb begin
        a1   = dm_addr + 9'd1;
        a2   = dm_addr + 9'd2;
        a3   = dm_addr + 9'd3;
        rd_w = {mem[a3], mem[a2], mem[a1], mem[dm_addr]};
        case (dm_op)
            LW:      dm_dout = rd_w;
            LH:      dm_dout = {{16{rd_w[15]}}, rd_w[15:0]};
            LHU:     dm_dout = {16'd0, rd_w[15:0]};
            LB:      dm_dout = {{24{rd_w[7]}}, rd_w[7:0]};
            LBU:     dm_dout = {24'd0, rd_w[7:0]};
            default: dm_dout = 32'd0;
        endcase
    end

    always @(posedge clk) begin
        if (dm_we) begin
            we_cnt <= we_cnt + 1;
            mem[dm_addr] <= dm_din[7:0];
            if (dm_op == SH || dm_op == SW) mem[a1] <= dm_din[15:8];
            if (dm_op == SW) begin
                mem[a2] <= dm_din[23:16];
                mem[a3] <= dm_din[31:24];
            end
        end
    end

    task automatic check(input string name, input logic [32:0] act, input logic [32:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest expected response of that port
    always @(negedge clk) begin
        if (rstn) begin
            if (done[0]) begin
                if (exp0_q.size() == 0) check("unexpected_done_p0", 33'd1, 33'd0);
                else check("resp_p0 {err,rdata}", {err[0], rd0}, exp0_q.pop_front());
            end
            if (done[1]) begin
                if (exp1_q.size() == 0) check("unexpected_done_p1", 33'd1, 33'd0);
                else check("resp_p1 {err,rdata}", {err[1], rd1}, exp1_q.pop_front());
            end
            if ((err & ~done) != 2'b00) check("err_without_done", {31'd0, err}, 33'd0);
        end
    end

    // Issue one access from port p at a negedge; exp_wait < 0 means grant timing unchecked
    task automatic access(input int p, input logic [2:0] o, input logic [8:0] a,
                          input logic [31:0] d, input logic e_err, input logic [31:0] e_rd,
                          input int exp_wait);
        int n;
        if (p == 0) exp0_q.push_back({e_err, e_rd});
        else        exp1_q.push_back({e_err, e_rd});
        op[p]    = o;
        addr[p]  = a;
        wdata[p] = d;
        req[p]   = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[p] && n < 20);
        req[p] = 1'b0;
        if (!gnt[p]) begin
            check($sformatf("gnt_timeout_p%0d", p), 33'd0, 33'd1);
        end else begin
            if (exp_wait >= 0) check($sformatf("gnt_wait_p%0d", p), 33'(n), 33'(exp_wait));
            @(negedge clk);
            check($sformatf("done_latency_p%0d", p), {32'd0, done[p]}, 33'd1);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0;
        int n;
        rstn = 1'b0;
        req  = 2'b00;
        for (int i = 0; i < 2; i++) begin
            op[i] = LW; addr[i] = 9'd0; wdata[i] = 32'd0;
        end
        repeat (3) @(negedge clk);

        // Reset values
        check("reset_handshake", {27'd0, gnt, done, err}, 33'd0);
        check("reset_rdata", {1'b0, rd0 | rd1}, 33'd0);
        check("reset_dm_ctrl", {20'd0, dm_we, dm_op, dm_addr}, 33'd0);
        check("reset_dm_din", {1'b0, dm_din}, 33'd0);
        rstn = 1'b1;

        // Tie right after reset: p0 first, p1 next IDLE
        fork
            access(0, SW, 9'h100, 32'hA5A5_A5A5, 1'b0, 32'd0, 1);
            access(1, SW, 9'h104, 32'h5A5A_5A5A, 1'b0, 32'd0, 4);
        join
        @(negedge clk);
        // Second tie: last grant was p1, so p0 wins again
        fork
            access(0, LW, 9'h104, 32'd0, 1'b0, 32'h5A5A_5A5A, 1);
            access(1, LW, 9'h100, 32'd0, 1'b0, 32'hA5A5_A5A5, 4);
        join

        // Single store then load
        w0 = we_cnt;
        access(0, SW, 9'h010, 32'hDEAD_BEEF, 1'b0, 32'd0, 2);
        check("store_we_pulses", 33'(we_cnt - w0), 33'd1);
        access(0, LW, 9'h010, 32'd0, 1'b0, 32'hDEAD_BEEF, 2);

        // Misaligned half store must not touch memory
        access(1, SW, 9'h020, 32'h1122_3344, 1'b0, 32'd0, -1);
        w0 = we_cnt;
        access(1, SH, 9'h021, 32'h0000_BEEF, 1'b1, 32'd0, 2);
        check("misaligned_we_pulses", 33'(we_cnt - w0), 33'd0);
        access(1, LW, 9'h020, 32'd0, 1'b0, 32'h1122_3344, 2);

        // Byte/half loads
        access(0, SW, 9'h040, 32'h80FF_7F01, 1'b0, 32'd0, -1);
        access(0, LB, 9'h043, 32'd0, 1'b0, 32'hFFFF_FF80, 2);
        access(0, LBU, 9'h043, 32'd0, 1'b0, 32'h0000_0080, 2);
        access(0, LH, 9'h042, 32'd0, 1'b0, 32'hFFFF_80FF, 2);
        access(0, LHU, 9'h042, 32'd0, 1'b0, 32'h0000_80FF, 2);
        access(0, LW, 9'h041, 32'd0, 1'b1, 32'd0, 2);

        // Reset in the middle of a store
        access(0, SW, 9'h050, 32'hCAFE_F00D, 1'b0, 32'd0, -1);
        op[0] = SW; addr[0] = 9'h050; wdata[0] = 32'h1234_5678; req[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!gnt[0] && n < 20);
        check("midstore_we_before_reset", {32'd0, dm_we}, 33'd1);
        rstn = 1'b0;
        #1;
        check("midstore_async_drop", {29'd0, dm_we, dm_op}, 33'd0);
        check("midstore_gnt_drop", {31'd0, gnt}, 33'd0);
        req[0] = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        access(0, LW, 9'h050, 32'd0, 1'b0, 32'hCAFE_F00D, 1);

        // Back-to-back with both ports always requesting: strict alternation, 3 cycles each
        @(negedge clk);
        fork
            for (int i = 0; i < 4; i++)
                access(1, LW, 9'h020, 32'd0, 1'b0, 32'h1122_3344, (i == 0) ? 1 : 5);
            for (int j = 0; j < 4; j++)
                access(0, LW, 9'h010, 32'd0, 1'b0, 32'hDEAD_BEEF, (j == 0) ? 4 : 5);
        join

        repeat (4) @(negedge clk);
        check("pending_p0", 33'(exp0_q.size()), 33'd0);
        check("pending_p1", 33'(exp1_q.size()), 33'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-low reset: clk input 1 (all state on rising edge); rstn input 1 (active-low, asynchronous assert, synchronous release).
REQ-002 Op encoding SHALL be 3 bits: LW 000, LH 001, LHU 010, LB 011, LBU 100, SW 101, SH 110, SB 111.
REQ-003 Per requester port p in {0 = CPU, 1 = DMA}, the block SHALL provide these inputs:
- pN_req input 1: access request, held high until pN_gnt.
- pN_op input 3: op code.
- pN_addr input 9: byte address.
- pN_wdata input 32: store data, LSB-aligned.
REQ-004 Per port p, the block SHALL provide these outputs:
- pN_gnt output 1: one-cycle pulse, request captured.
- pN_done output 1: one-cycle pulse, access complete.
- pN_err output 1: valid with pN_done, misaligned access.
- pN_rdata output 32: load result, valid with pN_done.
REQ-005 Memory-side ports SHALL be:
- dm_we output 1: write strobe.
- dm_op output 3: op to memory.
- dm_addr output 9: address to memory.
- dm_din output 32: store data.
- dm_dout input 32: combinational load data from memory.

Function
REQ-006 FSM SHALL have three states: IDLE, ACC, RSP.
REQ-007 Transitions SHALL be:
- IDLE->ACC when any pN_req is high.
- ACC->RSP unconditionally.
- RSP->IDLE unconditionally.
REQ-008 On the IDLE->ACC edge the block SHALL capture the winning port's op, addr and wdata and the winner id.
REQ-009 Arbitration SHALL be round-robin: a single requester wins; on simultaneous requests the port not granted last wins.
REQ-010 After reset the "last granted" register SHALL be port 1, so port 0 wins the first tie.
REQ-011 pN_gnt SHALL be high for exactly the ACC cycle of port N's access; a requester SHALL NOT change pN_op/addr/wdata while pN_req is high and gnt not yet seen.
REQ-012 Memory outputs SHALL be driven from captured registers only in ACC: dm_addr=addr, dm_din=wdata, dm_op=op.
REQ-013 In ACC, dm_we SHALL be 1 iff op is SW/SH/SB and the access is aligned.
REQ-014 Outside ACC, memory outputs SHALL be dm_op=000 (LW, non-writing), dm_we=0, dm_addr=0, dm_din=0.
REQ-015 Alignment SHALL be checked as follows:
- LW/SW require addr[1:0]==00.
- LH/LHU/SH require addr[0]==0.
- Byte ops are always aligned.
REQ-016 Misaligned accesses SHALL force dm_op=000 and dm_we=0 in ACC (no memory write), return rdata=0 and set err=1.
REQ-017 At the end of ACC, for an aligned load the block SHALL register dm_dout into the winner's rdata; for stores rdata SHALL be 0.
REQ-018 pN_done/pN_err/pN_rdata SHALL be asserted in RSP only, for the captured winner only; rdata SHALL hold its value until the next done for that port.
REQ-019 Latency SHALL be: req sampled high in IDLE cycle T -> gnt in T+1 -> done in T+2. Throughput SHALL be one access per 3 cycles.
REQ-020 The losing request SHALL stay pending and SHALL be granted on the next IDLE (starvation bound: one access).
REQ-021 A request arriving during ACC or RSP SHALL NOT be sampled until IDLE.
REQ-022 A port dropping req before gnt SHALL be treated as withdrawn; no access occurs.
REQ-023 Address arithmetic SHALL be 9-bit; addr+3 overflow is the memory's concern. The arbiter SHALL NOT modify the address.

Reset
REQ-024 On rstn low the block SHALL immediately enter IDLE; all outputs SHALL be 0 (dm_op=000), captured registers 0 and last-granted=1.
REQ-025 Reset asserted during ACC SHALL drop dm_we and dm_op to 000 asynchronously, so no store completes; no done pulse SHALL follow.
REQ-026 After rstn release the first possible gnt SHALL be 2 edges later (IDLE sample, then ACC).

Verification
REQ-027 The bench SHALL cover these directed scenarios:
- Single store then load: p0 SW addr 0x010 data 0xDEADBEEF -> dm_we=1 for one cycle, p0_done, err=0; then p0 LW 0x010 -> p0_rdata=0xDEADBEEF.
- Tie: p0 and p1 req same cycle after reset -> p0 granted first, p1 granted in the following IDLE; next tie -> p0 (last was p1).
- Misaligned: p1 SH addr 0x021 -> dm_we never 1, p1_done with p1_err=1, rdata=0, memory unchanged on readback.
- Byte/half loads: memory word 0x80FF7F01 at 0x040 -> LB 0x043 gives 0xFFFFFF80, LBU 0x043 gives 0x00000080, LH 0x042 gives 0xFFFF80FF.
- Reset mid-store: rstn low during ACC of SW 0x050 0x12345678 -> no done pulse, LW 0x050 after reset returns the prior value.
- Back-to-back p0 with p1 continuously requesting -> strict alternation, each access exactly 3 cycles.
